// File: rtl/fam_epoch_scheduler.sv
// fam_epoch_scheduler: sequences one epoch of the multi-FAM accumulator array
// (merge-row load, edge streaming, pipeline flush, result read-back, buffer swap).
// Optional build macro FAM_PERF_CNT_EN adds perf_stall / perf_cycles counters.
module fam_epoch_scheduler #(
  parameter int unsigned ADDRW  = 16,
  parameter int unsigned NUMFAM = 8,
  parameter int unsigned NLANE  = 4,
  parameter int unsigned CNTW   = 32,
  parameter int unsigned PIPE   = 8,
  parameter int unsigned RDLAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRW-1:0]         rows,
  input  logic [CNTW-1:0]          nedges,
  output logic                     busy,
  output logic                     done,
  output logic                     err_overrun,
  input  logic                     mg_valid,
  output logic                     mg_ready,
  output logic [NUMFAM-1:0]        fam_mgwrena,
  output logic [ADDRW*NUMFAM-1:0]  fam_mgwaddress,
  input  logic [NUMFAM*NLANE-1:0]  edge_valid,
  output logic                     edge_ready,
  output logic [ADDRW*NUMFAM-1:0]  fam_rurraddr,
  output logic                     rd_valid,
  output logic [ADDRW-1:0]         rd_addr,
  output logic [NUMFAM-1:0]        fam_dbsel
`ifdef FAM_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_cycles
`endif
);

  localparam int unsigned NEDGE = NUMFAM * NLANE;
  localparam int unsigned POPW  = $clog2(NEDGE + 1);
  localparam int unsigned WMAX  = (PIPE > RDLAT) ? PIPE : RDLAT;
  localparam int unsigned WW    = $clog2(WMAX + 1);
  localparam int unsigned SUMW  = CNTW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_READ   = 3'd4,
    S_SWAP   = 3'd5
  } state_e;

  state_e                        state_q, state_d;
  logic [ADDRW-1:0]              rows_q, rows_d;
  logic [CNTW-1:0]               nedges_q, nedges_d;
  logic [CNTW-1:0]               cnt_q, cnt_d;
  logic [ADDRW-1:0]              ld_ptr_q, ld_ptr_d;
  logic [ADDRW:0]                rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]                 wait_q, wait_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          edge_ready_q, edge_ready_d;
  logic                          dbsel_q, dbsel_d;
  logic [RDLAT-1:0]              rdv_sr_q, rdv_sr_d;
  logic [RDLAT-1:0][ADDRW-1:0]   rda_sr_q, rda_sr_d;

  logic [POPW-1:0]               pop;
  logic [SUMW-1:0]               sum;
  logic                          issue;
  logic                          load_fire;

`ifdef FAM_PERF_CNT_EN
  logic [31:0]                   stall_q, stall_d;
  logic [31:0]                   pcyc_q, pcyc_d;
`endif

  // Number of valid edge lanes this cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NEDGE); i++) begin
      pop = pop + POPW'(edge_valid[i]);
    end
  end

  assign load_fire = (state_q == S_LOAD) && mg_valid;

  // Next-state and datapath update for the epoch sequencer.
  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    nedges_d     = nedges_q;
    cnt_d        = cnt_q;
    ld_ptr_d     = ld_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wait_d       = wait_q;
    err_d        = err_q;
    dbsel_d      = dbsel_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    sum          = SUMW'(cnt_q) + SUMW'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d   = rows;
          nedges_d = nedges;
          cnt_d    = '0;
          ld_ptr_d = '0;
          wait_d   = '0;
          if (rows != '0) begin
            state_d = S_LOAD;
          end else if (nedges == '0) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_LOAD: begin
        if (mg_valid) begin
          ld_ptr_d = ld_ptr_q + ADDRW'(1);
          if (ld_ptr_q == rows_q - ADDRW'(1)) begin
            wait_d  = '0;
            state_d = (nedges_q == '0) ? S_FLUSH : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (sum > SUMW'(nedges_q)) begin
          cnt_d = nedges_q;
          err_d = 1'b1;
        end else begin
          cnt_d = CNTW'(sum);
        end
        if (cnt_d == nedges_q) begin
          wait_d  = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (wait_q == WW'(PIPE - 1)) begin
          wait_d   = '0;
          rd_ptr_d = '0;
          state_d  = (rows_q != '0) ? S_READ : S_SWAP;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_READ: begin
        if (rd_ptr_q < {1'b0, rows_q}) begin
          issue    = 1'b1;
          rd_ptr_d = rd_ptr_q + (ADDRW+1)'(1);
        end else if (wait_q == WW'(RDLAT - 1)) begin
          wait_d  = '0;
          state_d = S_SWAP;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_SWAP: begin
        dbsel_d = ~dbsel_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    edge_ready_d = (state_d == S_STREAM);
  end

  // Read-strobe and address delay line matching the FAM result latency.
  always_comb begin
    rdv_sr_d    = rdv_sr_q;
    rda_sr_d    = rda_sr_q;
    rdv_sr_d[0] = issue;
    rda_sr_d[0] = rd_ptr_q[ADDRW-1:0];
    for (int i = 1; i < int'(RDLAT); i++) begin
      rdv_sr_d[i] = rdv_sr_q[i-1];
      rda_sr_d[i] = rda_sr_q[i-1];
    end
  end

`ifdef FAM_PERF_CNT_EN
  // Epoch performance counters: cleared on start, frozen while idle.
  always_comb begin
    stall_d = stall_q;
    pcyc_d  = pcyc_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        stall_d = '0;
        pcyc_d  = '0;
      end
    end else begin
      pcyc_d = pcyc_q + 32'(1);
      if ((state_q == S_LOAD) && !mg_valid) begin
        stall_d = stall_q + 32'(1);
      end
    end
  end
`endif

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      nedges_q     <= '0;
      cnt_q        <= '0;
      ld_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      edge_ready_q <= 1'b0;
      dbsel_q      <= 1'b0;
      rdv_sr_q     <= '0;
      rda_sr_q     <= '0;
`ifdef FAM_PERF_CNT_EN
      stall_q      <= '0;
      pcyc_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      nedges_q     <= nedges_d;
      cnt_q        <= cnt_d;
      ld_ptr_q     <= ld_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wait_q       <= wait_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      edge_ready_q <= edge_ready_d;
      dbsel_q      <= dbsel_d;
      rdv_sr_q     <= rdv_sr_d;
      rda_sr_q     <= rda_sr_d;
`ifdef FAM_PERF_CNT_EN
      stall_q      <= stall_d;
      pcyc_q       <= pcyc_d;
`endif
    end
  end

  // Merge handshake is same-cycle so the host row lands with its write enable.
  assign mg_ready       = load_fire;
  assign fam_mgwrena    = {NUMFAM{load_fire}};
  assign fam_mgwaddress = {NUMFAM{ld_ptr_q}};
  assign fam_rurraddr   = {NUMFAM{rd_ptr_q[ADDRW-1:0]}};
  assign fam_dbsel      = {NUMFAM{dbsel_q}};
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_overrun    = err_q;
  assign edge_ready     = edge_ready_q;
  assign rd_valid       = rdv_sr_q[RDLAT-1];
  assign rd_addr        = rda_sr_q[RDLAT-1];
`ifdef FAM_PERF_CNT_EN
  assign perf_stall     = stall_q;
  assign perf_cycles    = pcyc_q;
`endif

endmodule

// File: tb/tb_fam_epoch_scheduler.sv
// Testbench for fam_epoch_scheduler: a cycle plan of inputs and expected outputs
// is built from epoch-level rules, driven into the DUT, and checked by a monitor.
module tb_fam_epoch_scheduler;

  localparam int unsigned ADDRW  = 16;
  localparam int unsigned NUMFAM = 8;
  localparam int unsigned NLANE  = 4;
  localparam int unsigned CNTW   = 32;
  localparam int          PIPE   = 8;
  localparam int          RDLAT  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [ADDRW-1:0]         rows_i;
  logic [CNTW-1:0]          nedges_i;
  logic                     busy, done, err_overrun;
  logic                     mg_valid, mg_ready;
  logic [NUMFAM-1:0]        fam_mgwrena;
  logic [ADDRW*NUMFAM-1:0]  fam_mgwaddress;
  logic [NUMFAM*NLANE-1:0]  edge_valid;
  logic                     edge_ready;
  logic [ADDRW*NUMFAM-1:0]  fam_rurraddr;
  logic                     rd_valid;
  logic [ADDRW-1:0]         rd_addr;
  logic [NUMFAM-1:0]        fam_dbsel;
`ifdef FAM_PERF_CNT_EN
  logic [31:0]              perf_stall, perf_cycles;
`endif

  fam_epoch_scheduler #(
    .ADDRW(ADDRW), .NUMFAM(NUMFAM), .NLANE(NLANE), .CNTW(CNTW), .PIPE(PIPE), .RDLAT(RDLAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rows(rows_i), .nedges(nedges_i),
    .busy(busy), .done(done), .err_overrun(err_overrun),
    .mg_valid(mg_valid), .mg_ready(mg_ready), .fam_mgwrena(fam_mgwrena),
    .fam_mgwaddress(fam_mgwaddress), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .fam_rurraddr(fam_rurraddr), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .fam_dbsel(fam_dbsel)
`ifdef FAM_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    bit           rst;
    bit           start;
    logic [15:0]  rows;
    logic [31:0]  nedges;
    bit           mgv;
    logic [31:0]  ev;
    bit           e_busy, e_eready, e_mgready, e_wr;
    logic [15:0]  e_waddr;
    bit           e_rdv;
    logic [15:0]  e_rda;
    bit           e_rr;
    logic [15:0]  e_rra;
    bit           e_done, e_dbsel, e_err, e_perf;
    int           e_stall, e_pcyc;
  } cyc_t;

  cyc_t        plan[$];
  cyc_t        sb[$];
  bit          mgpat[$];
  logic [31:0] edgpat[$];
  bit          m_dbsel, m_err;
  int          errors = 0;
  int          checks = 0;
  int          cyc_no = 0;

  // Idle cycle: random noise on inputs that must be ignored, quiet outputs expected.
  function automatic cyc_t idle_rec();
    cyc_t r;
    r.tag = "idle"; r.rst = 0; r.start = 0;
    r.rows = 16'($urandom); r.nedges = $urandom; r.mgv = 1'($urandom); r.ev = $urandom;
    r.e_busy = 0; r.e_eready = 0; r.e_mgready = 0; r.e_wr = 0; r.e_waddr = '0;
    r.e_rdv = 0; r.e_rda = '0; r.e_rr = 0; r.e_rra = '0; r.e_done = 0;
    r.e_dbsel = m_dbsel; r.e_err = m_err; r.e_perf = 0; r.e_stall = 0; r.e_pcyc = 0;
    return r;
  endfunction

  // Epoch model: phase lengths follow from the merge pattern (LOAD), edge words
  // until the total reaches nedges (STREAM), PIPE flush, rows+RDLAT read, one SWAP.
  task automatic add_epoch(input string tag, input int rows, input int unsigned ned,
                           input int gap, input bit hold, input int rst_at);
    cyc_t   r;
    int     L, T, R, D, base, wr;
    longint cum;
    bit     ovf;
    for (int g = 0; g < gap; g++) plan.push_back(idle_rec());
    r = plan.pop_back();
    r.start = 1; r.rows = 16'(rows); r.nedges = ned;
    plan.push_back(r);
    L = mgpat.size(); T = edgpat.size(); cum = 0;
    foreach (edgpat[j]) cum += $countones(edgpat[j]);
    ovf  = (cum > longint'(ned));
    R    = (rows > 0) ? rows + RDLAT : 0;
    base = L + T + PIPE;
    D    = base + R + 2;
    wr   = 0;
    for (int c = 1; c <= D; c++) begin
      r = idle_rec();
      r.tag = tag; r.start = hold;
      r.e_busy = (c < D); r.e_done = (c == D);
      if (c <= L) begin
        r.mgv = mgpat[c-1]; r.e_mgready = r.mgv; r.e_wr = r.mgv; r.e_waddr = 16'(wr);
        if (r.mgv) wr++;
      end
      if (c > L && c <= L + T) begin
        r.ev = edgpat[c-L-1]; r.e_eready = 1;
      end
      if (R > 0 && c > base && c <= base + R) begin
        int k;
        k = c - base - 1;
        if (k < rows) begin r.e_rr = 1; r.e_rra = 16'(k); end
        if (k >= RDLAT) begin r.e_rdv = 1; r.e_rda = 16'(k - RDLAT); end
      end
      r.e_err   = m_err | (ovf && c > L + T);
      r.e_dbsel = (c == D) ? ~m_dbsel : m_dbsel;
      if (c == D) begin r.e_perf = 1; r.e_stall = L - rows; r.e_pcyc = D - 1; end
      if (rst_at >= 0 && c == base + 1 + rst_at) begin
        r.rst = 1;
        plan.push_back(r);
        m_dbsel = 0; m_err = 0;
        plan.push_back(idle_rec());
        return;
      end
      plan.push_back(r);
    end
    m_dbsel = ~m_dbsel;
    m_err   = m_err | ovf;
  endtask

  task automatic gen_random(input int rows, input int unsigned ned);
    longint cum;
    logic [31:0] w;
    int ones;
    mgpat.delete(); edgpat.delete();
    ones = 0;
    while (ones < rows) begin
      bit b;
      b = ($urandom % 4) != 0;
      mgpat.push_back(b);
      if (b) ones++;
    end
    cum = 0;
    while (cum < longint'(ned)) begin
      if ($urandom % 8 == 0) w = '0;
      else if ($urandom % 8 == 0) w = '1;
      else w = $urandom & $urandom;
      edgpat.push_back(w);
      cum += $countones(w);
    end
  endtask

  // Monitor: pops one expected record per cycle and compares every observed output.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cyc_t e;
      bit ok;
      e = sb.pop_front();
      ok = 1;
      if (busy !== e.e_busy || done !== e.e_done || err_overrun !== e.e_err) ok = 0;
      if (edge_ready !== e.e_eready || mg_ready !== e.e_mgready) ok = 0;
      if (fam_mgwrena !== {NUMFAM{e.e_wr}} || fam_dbsel !== {NUMFAM{e.e_dbsel}}) ok = 0;
      if (rd_valid !== e.e_rdv) ok = 0;
      if (e.e_rdv && rd_addr !== e.e_rda) ok = 0;
      for (int f = 0; f < int'(NUMFAM); f++) begin
        if (e.e_wr && fam_mgwaddress[f*ADDRW +: ADDRW] !== e.e_waddr) ok = 0;
        if (e.e_rr && fam_rurraddr[f*ADDRW +: ADDRW] !== e.e_rra) ok = 0;
      end
`ifdef FAM_PERF_CNT_EN
      if (e.e_perf && (perf_stall !== 32'(e.e_stall) || perf_cycles !== 32'(e.e_pcyc))) ok = 0;
`endif
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s cyc=%0d got busy=%b done=%b err=%b er=%b mr=%b wen=%h wa=%h rv=%b ra=%h rr=%h db=%h | required busy=%b done=%b err=%b er=%b mr=%b wen=%b wa=%h rv=%b ra=%h rr=%h db=%b",
                 e.tag, cyc_no, busy, done, err_overrun, edge_ready, mg_ready, fam_mgwrena,
                 fam_mgwaddress[ADDRW-1:0], rd_valid, rd_addr, fam_rurraddr[ADDRW-1:0], fam_dbsel,
                 e.e_busy, e.e_done, e.e_err, e.e_eready, e.e_mgready, e.e_wr, e.e_waddr,
                 e.e_rdv, e.e_rda, e.e_rra, e.e_dbsel);
      end
    end
    cyc_no++;
  end

  initial begin
    m_dbsel = 0; m_err = 0;
    plan.push_back(idle_rec());

    // Overrun: 32 edges in one cycle against nedges=8.
    mgpat.delete(); edgpat.delete();
    repeat (4) mgpat.push_back(1);
    edgpat.push_back(32'hFFFF_FFFF);
    add_epoch("overrun", 4, 8, 1, 0, -1);

    // Two lanes per cycle, 10 edges: five streaming cycles.
    mgpat.delete(); edgpat.delete();
    repeat (4) mgpat.push_back(1);
    repeat (5) edgpat.push_back(32'h0000_0003);
    add_epoch("two_lane", 4, 10, 2, 0, -1);

    // Merge stalls on alternate cycles.
    mgpat.delete(); edgpat.delete();
    for (int i = 0; i < 5; i++) mgpat.push_back((i % 2) == 0);
    edgpat.push_back(32'h0000_001F);
    add_epoch("mg_stall", 3, 5, 1, 0, -1);

    // Empty epoch: flush and swap only.
    mgpat.delete(); edgpat.delete();
    add_epoch("empty", 0, 0, 1, 0, -1);

    // Reset in the middle of READ aborts without done.
    mgpat.delete(); edgpat.delete();
    repeat (5) mgpat.push_back(1);
    edgpat.push_back(32'h0000_0007); edgpat.push_back(32'h0000_0007);
    add_epoch("rst_read", 5, 6, 1, 0, 3);

    // Start held high: second epoch begins from the done cycle.
    mgpat.delete(); edgpat.delete();
    repeat (2) mgpat.push_back(1);
    edgpat.push_back(32'h0000_000F);
    add_epoch("hold1", 2, 4, 1, 1, -1);
    mgpat.delete(); edgpat.delete();
    mgpat.push_back(1);
    edgpat.push_back(32'h0000_0007);
    add_epoch("hold2", 1, 3, 0, 0, -1);

    // Randomised epochs.
    for (int n = 0; n < 20; n++) begin
      int rws;
      int unsigned ned;
      rws = $urandom_range(0, 12);
      ned = ($urandom % 4 == 0) ? 0 : $urandom_range(1, 60);
      gen_random(rws, ned);
      add_epoch("random", rws, ned, $urandom_range(0, 2), 0, -1);
    end

    rst_n = 0; start = 0; rows_i = '0; nedges_i = '0; mg_valid = 0; edge_valid = '0;
    repeat (3) @(posedge clk);
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst_n      = !plan[i].rst;
      start      = plan[i].start;
      rows_i     = plan[i].rows;
      nedges_i   = plan[i].nedges;
      mg_valid   = plan[i].mgv;
      edge_valid = plan[i].ev;
      sb.push_back(plan[i]);
    end
    @(posedge clk);
    #1;
    rst_n = 1; start = 0; mg_valid = 0; edge_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending records, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
